// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze on pending memory access, multi-cycle mul/div hold,
// branch flush and load-use interlock. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_ctrl #(
  parameter int RF_AWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RF_AWIDTH-1:0] rs1_addr_id,
  input  logic [RF_AWIDTH-1:0] rs2_addr_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic                 dmem_rd_ex,
  input  logic                 regfile_wen_ex,
  input  logic [RF_AWIDTH-1:0] rd_addr_ex,
  input  logic                 dmem_rd_dm,
  input  logic                 regfile_wen_dm,
  input  logic [RF_AWIDTH-1:0] rd_addr_dm,
  input  logic                 branch_taken_ex,
  input  logic                 md_start_ex,
  input  logic                 md_done,
  input  logic                 dmem_req_dm,
  input  logic                 dmem_ack,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_dm,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 bubble_dm,
  output logic                 pc_redirect,
  output logic [1:0]           ctrl_state,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MDWAIT  = 2'b01,
    ST_MEMWAIT = 2'b10,
    ST_RSVD    = 2'b11
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  state_t eff_state;
  logic   md_done_q, md_done_d;
  logic   freeze;
  logic   ex_load, dm_load;
  logic   ex_hit, dm_hit, load_use;

  assign freeze = dmem_req_dm & ~dmem_ack;

  // A load can only cause a hazard if it really writes a non-zero register.
  assign ex_load = dmem_rd_ex & regfile_wen_ex & (|rd_addr_ex);
  assign dm_load = dmem_rd_dm & regfile_wen_dm & (|rd_addr_dm);

  assign ex_hit = ex_load & ((rs1_used_id & (rs1_addr_id == rd_addr_ex)) |
                             (rs2_used_id & (rs2_addr_id == rd_addr_ex)));
  assign dm_hit = dm_load & ((rs1_used_id & (rs1_addr_id == rd_addr_dm)) |
                             (rs2_used_id & (rs2_addr_id == rd_addr_dm)));
  assign load_use = ex_hit | dm_hit;

  // Once the memory freeze lifts, behave exactly as the interrupted state would.
  always_comb begin
    unique case (state_q)
      ST_MDWAIT:  eff_state = ST_MDWAIT;
      ST_MEMWAIT: eff_state = (ret_q == ST_MDWAIT) ? ST_MDWAIT : ST_RUN;
      default:    eff_state = ST_RUN;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    ret_d       = ret_q;
    md_done_d   = md_done_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_dm    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    bubble_dm   = 1'b0;
    pc_redirect = 1'b0;

    if (freeze) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      stall_dm = 1'b1;
      state_d  = ST_MEMWAIT;
      if (state_q != ST_MEMWAIT) ret_d = eff_state;
      if (md_done) md_done_d = 1'b1;
    end else if (eff_state == ST_MDWAIT) begin
      if (md_done || md_done_q) begin
        state_d   = ST_RUN;
        md_done_d = 1'b0;
      end else begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        bubble_dm = 1'b1;
        state_d   = ST_MDWAIT;
      end
    end else begin
      state_d   = ST_RUN;
      md_done_d = 1'b0;
      if (branch_taken_ex) begin
        pc_redirect = 1'b1;
        flush_id    = 1'b1;
        flush_ex    = 1'b1;
      end else if (md_start_ex) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        bubble_dm = 1'b1;
        state_d   = ST_MDWAIT;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end

    // Control outputs are silenced for the whole time reset is held.
    if (rst) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_dm    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      bubble_dm   = 1'b0;
      pc_redirect = 1'b0;
    end
  end

  // NOTE: asynchronous reset in the sensitivity list; state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      md_done_q <= md_done_d;
    end
  end

  assign ctrl_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  pipeline clock, rising-edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
REQ-003 SHALL have: rs1_addr_id, rs2_addr_id  in  RF_AWIDTH  ID-stage source register addresses.
REQ-004 SHALL have: rs1_used_id, rs2_used_id  in  1  ID instruction actually reads rs1/rs2.
REQ-005 SHALL have: dmem_rd_ex, regfile_wen_ex  in  1; rd_addr_ex  in  RF_AWIDTH  EX-stage load flag, write-enable, destination.
REQ-006 SHALL have: dmem_rd_dm, regfile_wen_dm  in  1; rd_addr_dm  in  RF_AWIDTH  DM-stage equivalents.
REQ-007 SHALL have: branch_taken_ex  in  1  taken branch/jump resolved in EX.
REQ-008 SHALL have: md_start_ex  in  1  multi-cycle mul/div in EX; md_done  in  1  single-cycle completion pulse.
REQ-009 SHALL have: dmem_req_dm  in  1  DM access pending; dmem_ack  in  1  memory completes access this cycle.
REQ-010 SHALL have: stall_if, stall_id, stall_ex, stall_dm  out  1  hold the stage register.
REQ-011 SHALL have: flush_id, flush_ex, bubble_dm  out  1  load NOP into ID/EX/DM register; pc_redirect  out  1  accept branch target.
REQ-012 SHALL have: ctrl_state  out  2  FSM state; stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-013 SHALL implement states RUN=2'b00, MDWAIT=2'b01, MEMWAIT=2'b10; 2'b11 unreachable, decoded as RUN.
REQ-014 SHALL define freeze = dmem_req_dm & ~dmem_ack, evaluated combinationally in every state; highest priority.
REQ-015 During freeze: stall_if/id/ex/dm=1, all flush/bubble/pc_redirect=0; state -> MEMWAIT; return register saves RUN or MDWAIT (current state if not MEMWAIT).
REQ-016 In MEMWAIT, the first non-freeze cycle SHALL evaluate as the saved return state, same cycle (zero added latency after dmem_ack).
REQ-017 Priority when not frozen: MDWAIT hold > branch flush > load-use stall > pass.
REQ-018 RUN, md_start_ex=1, branch_taken_ex=0: stall_if/id/ex=1, bubble_dm=1; next state MDWAIT; branch_taken_ex=1 SHALL override md_start_ex.
REQ-019 MDWAIT: same outputs as REQ-018 until md_done (or latched md_done_q) seen; that cycle all stalls=0, next state RUN.
REQ-020 md_done arriving while frozen SHALL set md_done_q; cleared on entry to RUN or rst.
REQ-021 Branch (RUN, branch_taken_ex=1): pc_redirect=1, flush_id=1, flush_ex=1, no stalls; load-use suppressed that cycle.
REQ-022 Load-use match: (dmem_rd_ex & regfile_wen_ex & rd_addr_ex!=0) or (dmem_rd_dm & regfile_wen_dm & rd_addr_dm!=0), address equal to rs1_addr_id with rs1_used_id, or rs2_addr_id with rs2_used_id.
REQ-023 Load-use: stall_if=1, stall_id=1, flush_ex=1; combinational, no state change; load in EX yields 2 bubbles total, load in DM yields 1.
REQ-024 Otherwise all control outputs SHALL be 0.

Reset
REQ-025 rst SHALL asynchronously force state=RUN, return register=RUN, md_done_q=0, stall_cnt=0, flush_cnt=0.
REQ-026 While rst=1 all control outputs SHALL be 0; reset mid-MDWAIT/MEMWAIT abandons the operation, no pending flags survive.

Configuration
REQ-027 Macro HAZARD_PERF_EN defined: stall_cnt increments each cycle stall_if=1; flush_cnt increments each cycle pc_redirect=1; both saturate at 32'hFFFF_FFFF.
REQ-028 HAZARD_PERF_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 0; all other behaviour identical.

Verification
REQ-029 lw x5 in EX (rd=5, wen, rd), ID reads rs1=5 -> cycle0 stall_if/id=1, flush_ex=1; cycle1 (load in DM) same; cycle2 outputs 0.
REQ-030 md_start_ex=1 in RUN, md_done at cycle 4 -> ctrl_state=01 cycles1-4, stall_if/id/ex=1, bubble_dm=1 cycles0-3, all 0 and RUN at cycle4/5.
REQ-031 dmem_req_dm=1, dmem_ack low 3 cycles during MDWAIT, md_done pulsed cycle1 -> ctrl_state=10 during freeze; ack cycle releases stalls, state RUN next.
REQ-032 branch_taken_ex=1 with md_start_ex=1 and load-use match -> pc_redirect=1, flush_id=1, flush_ex=1, no stalls, state stays RUN.
REQ-033 rst asserted mid-MDWAIT -> state 00, outputs 0 immediately; HAZARD_PERF_EN: after 10 stall cycles stall_cnt=10; undefined: stall_cnt=0.
